shift_unit_pipe: RTL and testbench
==================================

// Module: shift_unit_pipe
// PURPOSE
//  Two-stage pipelined shift execution unit for the RV32I datapath.
//  - Sits directly upstream of the existing logical-right barrel `shifter` (inA/inB/en -> out),
//    which it instantiates, and directly downstream of it via a registered result stage.
//  - Derives SLL, SRL and SRA from the right-only shifter using bit reversal and sign fill.
//  - Valid/ready handshake on both the operation side and the result side.
// PARAMETERS
//  TAG_W   5   width of the opaque tag (rd index) carried alongside each op
// PORTS
//  i_clk       in   1      clock; all state updates on the rising edge
//  i_rst_n     in   1      asynchronous, active-low reset
//  i_flush     in   1      synchronous kill of all in-flight ops
//  i_op_valid  in   1      op request valid
//  o_op_ready  out  1      unit can accept an op this cycle
//  i_op        in   2      00 SLL, 01 SRL, 11 SRA, 10 ROR (see CONFIGURATION)
//  i_a         in   32     operand to shift
//  i_shamt     in   5      shift amount 0..31
//  i_tag       in   TAG_W  passthrough tag
//  o_res_valid out  1      result valid
//  i_res_ready in   1      consumer accepts the result
//  o_res       out  32     shifted result
//  o_res_tag   out  TAG_W  tag of the result
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): s1_v=0, s2_v=0, o_res_valid=0, o_res=0, o_res_tag=0, o_op_ready=1.
//  - Accept: i_op_valid & o_op_ready & ~i_flush. The op is latched into S1 as: op, shamt, tag,
//    sign=a[31], and pa = (op==SLL) ? bitrev(a) : a.
//  - S1 (combinational, from registers):
//    - r = shifter(pa, shamt, en=s1_v)
//    - m = shifter(32'hFFFF_FFFF, shamt, en=s1_v)
//    - SLL: bitrev(r); SRL: r; SRA: r | (sign ? ~m : 0)
//  - S2: a registered result. It loads when s1_v & (~s2_v | i_res_ready).
//  - Readiness: o_op_ready = ~i_flush & (~s1_v | ~s2_v | i_res_ready).
//    - Capacity is 2 ops. There is no bubble under continuous flow.
//  - Latency: accept at edge N; o_res_valid is high after edge N+1 when S2 is free.
//  - Ordering: results are delivered strictly in acceptance order. No op is dropped or duplicated.
//  - Result hold: o_res and o_res_tag stay stable while o_res_valid & ~i_res_ready.
//  - i_flush=1:
//    - Next edge: s1_v=0, s2_v=0, o_res_valid=0.
//    - No accept happens that cycle; flush wins over a simultaneous i_op_valid.
//    - A result handshake in the same cycle is treated as not delivered.
//  - Boundaries:
//    - shamt=0 returns i_a unchanged for every op.
//    - shamt=31 SRA of a negative operand gives 0xFFFF_FFFF.
//    - Simultaneous accept into S1 and S1->S2 transfer is legal every cycle.
//  - Reset mid-operation discards all in-flight ops immediately (async).
// CONFIGURATION
//  SHIFT_ROR_EN defined:
//    - op 10 = ROR: res = r | bitrev(shifter(bitrev(pa), (-shamt)&31)).
//    - This uses a third shifter instance.
//    - shamt=0 yields a.
//  SHIFT_ROR_EN undefined:
//    - op 10 behaves exactly as SRL (01).
//    - Only two shifter instances.
// STRUCTURE
//  - Shared package shift_pkg:
//    - typedef enum logic [1:0] shift_op_e {SH_SLL, SH_SRL, SH_ROR, SH_SRA}
//    - function bitrev32
//    - localparam XLEN=32
//  - Sub-modules: existing `shifter` only (2 or 3 instances). The valid/ready control lives in this file.
// TESTING
//  1. SLL a=0x0000_0001 shamt=31 -> o_res=0x8000_0000, o_res_valid one edge after accept.
//  2. SRA a=0x8000_0000 shamt=4 -> 0xF800_0000; SRL same operands -> 0x0800_0000;
//     SRA a=0x7000_0000 shamt=4 -> 0x0700_0000.
//  3. Three back-to-back ops, i_res_ready=0 for 4 cycles -> o_op_ready drops after 2 accepts;
//     on release the results drain in order with their tags.
//  4. Both stages full, i_flush=1 with i_op_valid=1 -> next cycle o_res_valid=0, op not accepted, o_op_ready=1.
//  5. Drop i_rst_n while an op is in S1 -> o_res_valid=0 and o_res=0 without waiting for a clock edge.
//  6. op=10 a=0x0000_00F1 shamt=4 -> 0x1000_000F with SHIFT_ROR_EN; 0x0000_000F without.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shift unit: operation encoding,
// datapath width and a 32-bit bit-reversal helper.
package shift_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_ROR = 2'b10,
    SH_SRA = 2'b11
  } shift_op_e;

  function automatic logic [XLEN-1:0] bitrev32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    for (int i = 0; i < XLEN; i++) begin
      y[i] = x[XLEN-1-i];
    end
    return y;
  endfunction

endpackage

// File: rtl/shifter.sv
// Logical-right barrel shifter: out = en ? (inA >> inB) : 0.
// Five log stages, one per shift-amount bit.
module shifter
  import shift_pkg::*;
(
  input  logic [XLEN-1:0] inA,
  input  logic [4:0]      inB,
  input  logic            en,
  output logic [XLEN-1:0] out
);

  logic [XLEN-1:0] stage [0:5];

  // NOTE: every combinational output is assigned on all paths, so no latches are inferred.
  always_comb begin
    stage[0] = inA;
    for (int k = 0; k < 5; k++) begin
      stage[k+1] = inB[k] ? (stage[k] >> (1 << k)) : stage[k];
    end
    out = en ? stage[5] : '0;
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage valid/ready shift unit built on the right-only `shifter`.
// Define SHIFT_ROR_EN to make op 2'b10 a rotate-right (third shifter); otherwise it acts as SRL.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [1:0]       i_op,
  input  logic [XLEN-1:0]  i_a,
  input  logic [4:0]       i_shamt,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [XLEN-1:0]  o_res,
  output logic [TAG_W-1:0] o_res_tag
);

  localparam logic [XLEN-1:0] ALL_ONES = '1;

  // Stage 1: the accepted op, with the operand pre-reversed for left shifts.
  logic             s1_v_d,     s1_v_q;
  shift_op_e        s1_op_d,    s1_op_q;
  logic [4:0]       s1_shamt_d, s1_shamt_q;
  logic [TAG_W-1:0] s1_tag_d,   s1_tag_q;
  logic             s1_sign_d,  s1_sign_q;
  logic [XLEN-1:0]  s1_pa_d,    s1_pa_q;

  // Stage 2: registered result presented to the consumer.
  logic             s2_v_d,     s2_v_q;
  logic [XLEN-1:0]  res_d,      res_q;
  logic [TAG_W-1:0] res_tag_d,  res_tag_q;

  logic             op_ready;
  logic             accept;
  logic             s2_load;
  logic [XLEN-1:0]  shr_r;
  logic [XLEN-1:0]  shr_m;
  logic [XLEN-1:0]  s1_res;

  shifter u_shift_data (
    .inA (s1_pa_q),
    .inB (s1_shamt_q),
    .en  (s1_v_q),
    .out (shr_r)
  );

  shifter u_shift_mask (
    .inA (ALL_ONES),
    .inB (s1_shamt_q),
    .en  (s1_v_q),
    .out (shr_m)
  );

`ifdef SHIFT_ROR_EN
  logic [4:0]      rot_amt;
  logic [XLEN-1:0] rot_in;
  logic [XLEN-1:0] rot_r;

  // Left shift by (32 - shamt) done as reverse / right-shift / reverse; shamt=0 wraps to 0.
  assign rot_amt = 5'd0 - s1_shamt_q;
  assign rot_in  = bitrev32(s1_pa_q);

  shifter u_shift_rot (
    .inA (rot_in),
    .inB (rot_amt),
    .en  (s1_v_q),
    .out (rot_r)
  );
`endif

  always_comb begin
    s1_res = shr_r;
    unique case (s1_op_q)
      SH_SLL: s1_res = bitrev32(shr_r);
      SH_SRL: s1_res = shr_r;
      SH_SRA: s1_res = shr_r | (s1_sign_q ? ~shr_m : '0);
`ifdef SHIFT_ROR_EN
      SH_ROR: s1_res = shr_r | bitrev32(rot_r);
`else
      SH_ROR: s1_res = shr_r;
`endif
      default: s1_res = shr_r;
    endcase
  end

  // S1 frees up whenever it is empty or its op moves to S2 this cycle.
  assign op_ready = ~i_flush & (~s1_v_q | ~s2_v_q | i_res_ready);
  assign accept   = i_op_valid & op_ready;
  assign s2_load  = s1_v_q & (~s2_v_q | i_res_ready);

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_op_d    = s1_op_q;
    s1_shamt_d = s1_shamt_q;
    s1_tag_d   = s1_tag_q;
    s1_sign_d  = s1_sign_q;
    s1_pa_d    = s1_pa_q;
    s2_v_d     = s2_v_q;
    res_d      = res_q;
    res_tag_d  = res_tag_q;

    if (accept) begin
      s1_op_d    = shift_op_e'(i_op);
      s1_shamt_d = i_shamt;
      s1_tag_d   = i_tag;
      s1_sign_d  = i_a[XLEN-1];
      s1_pa_d    = (shift_op_e'(i_op) == SH_SLL) ? bitrev32(i_a) : i_a;
    end

    if (s2_load) begin
      res_d     = s1_res;
      res_tag_d = s1_tag_q;
    end

    // Flush wins over both an accept and a same-cycle result handshake.
    if (i_flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end else begin
      if (accept)       s1_v_d = 1'b1;
      else if (s2_load) s1_v_d = 1'b0;

      if (s2_load)          s2_v_d = 1'b1;
      else if (i_res_ready) s2_v_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: payload registers are reset as well so the observable result is zero out of reset.
      s1_v_q     <= 1'b0;
      s1_op_q    <= SH_SLL;
      s1_shamt_q <= '0;
      s1_tag_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_pa_q    <= '0;
      s2_v_q     <= 1'b0;
      res_q      <= '0;
      res_tag_q  <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_op_q    <= s1_op_d;
      s1_shamt_q <= s1_shamt_d;
      s1_tag_q   <= s1_tag_d;
      s1_sign_q  <= s1_sign_d;
      s1_pa_q    <= s1_pa_d;
      s2_v_q     <= s2_v_d;
      res_q      <= res_d;
      res_tag_q  <= res_tag_d;
    end
  end

  assign o_op_ready  = op_ready;
  assign o_res_valid = s2_v_q;
  assign o_res       = res_q;
  assign o_res_tag   = res_tag_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe: directed vector table, hand-written
// backpressure/flush/reset sequences, and randomized traffic against a queue model.
module tb_shift_unit_pipe;

  localparam int TAG_W = 5;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_flush;
  logic             i_op_valid;
  logic             o_op_ready;
  logic [1:0]       i_op;
  logic [31:0]      i_a;
  logic [4:0]       i_shamt;
  logic [TAG_W-1:0] i_tag;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [31:0]      o_res;
  logic [TAG_W-1:0] o_res_tag;

  shift_unit_pipe #(.TAG_W(TAG_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_op_valid  (i_op_valid),
    .o_op_ready  (o_op_ready),
    .i_op        (i_op),
    .i_a         (i_a),
    .i_shamt     (i_shamt),
    .i_tag       (i_tag),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res       (o_res),
    .o_res_tag   (o_res_tag)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic shifts, rotate taken from a doubled word.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [4:0] s);
    int          n;
    logic [63:0] dbl;
    n   = int'(s);
    dbl = {a, a};
    case (op)
      OP_SLL:  return a << n;
      OP_SRL:  return a >> n;
      OP_SRA:  return $signed(a) >>> n;
`ifdef SHIFT_ROR_EN
      default: return dbl[n +: 32];
`else
      default: return (dbl[31:0] >> n);
`endif
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] s, input logic [TAG_W-1:0] tag,
                       input logic rr, input logic fl);
    i_op_valid  = v;
    i_op        = op;
    i_a         = a;
    i_shamt     = s;
    i_tag       = tag;
    i_res_ready = rr;
    i_flush     = fl;
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, OP_SLL, 32'h0, 5'd0, '0, rr, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        fl, v, rr;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  s;
    logic [TAG_W-1:0] tag;
    exp_t        e;
    logic [31:0] ror_exp;

`ifdef SHIFT_ROR_EN
    ror_exp = 32'h1000_000F;
`else
    ror_exp = 32'h0000_000F;
`endif
    vecs[0]  = '{op: OP_SLL, a: 32'h0000_0001, shamt: 5'd31, exp: 32'h8000_0000, name: "sll_1_31"};
    vecs[1]  = '{op: OP_SRA, a: 32'h8000_0000, shamt: 5'd4,  exp: 32'hF800_0000, name: "sra_neg_4"};
    vecs[2]  = '{op: OP_SRL, a: 32'h8000_0000, shamt: 5'd4,  exp: 32'h0800_0000, name: "srl_4"};
    vecs[3]  = '{op: OP_SRA, a: 32'h7000_0000, shamt: 5'd4,  exp: 32'h0700_0000, name: "sra_pos_4"};
    vecs[4]  = '{op: OP_SRA, a: 32'h8000_0001, shamt: 5'd31, exp: 32'hFFFF_FFFF, name: "sra_neg_31"};
    vecs[5]  = '{op: OP_SLL, a: 32'hDEAD_BEEF, shamt: 5'd0,  exp: 32'hDEAD_BEEF, name: "sll_0"};
    vecs[6]  = '{op: OP_SRL, a: 32'hDEAD_BEEF, shamt: 5'd0,  exp: 32'hDEAD_BEEF, name: "srl_0"};
    vecs[7]  = '{op: OP_SRA, a: 32'hA5A5_A5A5, shamt: 5'd0,  exp: 32'hA5A5_A5A5, name: "sra_0"};
    vecs[8]  = '{op: OP_ROR, a: 32'h0000_00F1, shamt: 5'd0,  exp: 32'h0000_00F1, name: "ror_0"};
    vecs[9]  = '{op: OP_ROR, a: 32'h0000_00F1, shamt: 5'd4,  exp: ror_exp,       name: "ror_4"};
    vecs[10] = '{op: OP_SLL, a: 32'h1234_5678, shamt: 5'd4,  exp: 32'h2345_6780, name: "sll_4"};
    vecs[11] = '{op: OP_SRL, a: 32'hFFFF_FFFF, shamt: 5'd31, exp: 32'h0000_0001, name: "srl_31"};

    i_rst_n = 1'b0;
    idle(1'b0);
    #1;
    check("rst_res_valid", 32'(o_res_valid), 32'd0);
    check("rst_res",       o_res,            32'd0);
    check("rst_res_tag",   32'(o_res_tag),   32'd0);
    check("rst_op_ready",  32'(o_op_ready),  32'd1);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed vectors: accept, one-cycle-late check, then result.
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].shamt, TAG_W'(i), 1'b1, 1'b0);
      #1 check({vecs[i].name, "_ready"}, 32'(o_op_ready), 32'd1);
      @(negedge i_clk);
      idle(1'b1);
      #1 check({vecs[i].name, "_early"}, 32'(o_res_valid), 32'd0);
      @(negedge i_clk);
      #1;
      check({vecs[i].name, "_valid"}, 32'(o_res_valid), 32'd1);
      check(vecs[i].name, o_res, vecs[i].exp);
      check({vecs[i].name, "_tag"}, 32'(o_res_tag), 32'(i));
    end

    // Backpressure: three ops, consumer stalled for four cycles.
    @(negedge i_clk);
    drive(1'b1, OP_SLL, 32'h0000_00FF, 5'd8, 5'd10, 1'b0, 1'b0);
    #1 check("bp_ready_a", 32'(o_op_ready), 32'd1);
    @(negedge i_clk);
    drive(1'b1, OP_SRA, 32'hF000_0000, 5'd8, 5'd11, 1'b0, 1'b0);
    #1 check("bp_ready_b", 32'(o_op_ready), 32'd1);
    @(negedge i_clk);
    drive(1'b1, OP_SRL, 32'h1234_5678, 5'd12, 5'd12, 1'b0, 1'b0);
    #1;
    check("bp_full_ready", 32'(o_op_ready), 32'd0);
    check("bp_hold_res1",  o_res, 32'h0000_FF00);
    @(negedge i_clk);
    #1;
    check("bp_full_ready2", 32'(o_op_ready), 32'd0);
    check("bp_hold_res2",   o_res, 32'h0000_FF00);
    check("bp_hold_tag2",   32'(o_res_tag), 32'd10);
    @(negedge i_clk);
    i_res_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(o_op_ready), 32'd1);
    check("bp_res_a", o_res, 32'h0000_FF00);
    @(negedge i_clk);
    idle(1'b1);
    #1;
    check("bp_valid_b", 32'(o_res_valid), 32'd1);
    check("bp_res_b", o_res, 32'hFFF0_0000);
    check("bp_tag_b", 32'(o_res_tag), 32'd11);
    @(negedge i_clk);
    #1;
    check("bp_valid_c", 32'(o_res_valid), 32'd1);
    check("bp_res_c", o_res, 32'h0001_2345);
    check("bp_tag_c", 32'(o_res_tag), 32'd12);
    @(negedge i_clk);
    #1 check("bp_drained", 32'(o_res_valid), 32'd0);

    // Flush with both stages full and a competing op request.
    @(negedge i_clk);
    drive(1'b1, OP_SLL, 32'h1, 5'd1, 5'd1, 1'b0, 1'b0);
    @(negedge i_clk);
    drive(1'b1, OP_SLL, 32'h2, 5'd1, 5'd2, 1'b0, 1'b0);
    @(negedge i_clk);
    drive(1'b1, OP_SRL, 32'h3, 5'd0, 5'd3, 1'b1, 1'b1);
    #1;
    check("fl_ready_during", 32'(o_op_ready), 32'd0);
    check("fl_valid_before", 32'(o_res_valid), 32'd1);
    @(negedge i_clk);
    idle(1'b1);
    #1;
    check("fl_valid_after", 32'(o_res_valid), 32'd0);
    check("fl_ready_after", 32'(o_op_ready), 32'd1);
    @(negedge i_clk);
    #1 check("fl_no_accept", 32'(o_res_valid), 32'd0);

    // Asynchronous reset with one op in S2 and one in S1.
    @(negedge i_clk);
    drive(1'b1, OP_SRL, 32'hCAFE_0000, 5'd4, 5'd7, 1'b0, 1'b0);
    @(negedge i_clk);
    drive(1'b1, OP_SLL, 32'h5, 5'd1, 5'd8, 1'b0, 1'b0);
    @(negedge i_clk);
    idle(1'b0);
    #1;
    check("ar_valid_before", 32'(o_res_valid), 32'd1);
    check("ar_res_before", o_res, 32'h0CAF_E000);
    #2 i_rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(o_res_valid), 32'd0);
    check("ar_res", o_res, 32'd0);
    check("ar_tag", 32'(o_res_tag), 32'd0);
    check("ar_ready", 32'(o_op_ready), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Randomized traffic against an in-order scoreboard.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge i_clk);
      fl  = ($urandom_range(0, 99) < 3);
      v   = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 2) != 0);
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      s   = 5'($urandom_range(0, 31));
      tag = TAG_W'($urandom);
      drive(v, op, a, s, tag, rr, fl);
      #1;
      check("rnd_ready", 32'(o_op_ready), 32'(!fl && (sb.size() < 2 || rr)));
      if (fl) begin
        sb.delete();
      end else begin
        if (o_res_valid && sb.size() == 0) begin
          check("rnd_spurious_valid", 32'(o_res_valid), 32'd0);
        end else if (o_res_valid && rr) begin
          e = sb.pop_front();
          check("rnd_res", o_res, e.res);
          check("rnd_tag", 32'(o_res_tag), 32'(e.tag));
        end
        if (v && o_op_ready) sb.push_back('{res: ref_shift(op, a, s), tag: tag});
      end
    end

    // Drain remaining results within a bounded number of cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      idle(1'b1);
      #1;
      if (o_res_valid) begin
        if (sb.size() == 0) begin
          check("drain_spurious_valid", 32'(o_res_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("drain_res", o_res, e.res);
          check("drain_tag", 32'(o_res_tag), 32'(e.tag));
        end
      end
    end
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
